// File: rtl/pipelined_adder_pkg.sv
// Shared constants and types for the pipelined ripple-carry adder.
package pipelined_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CHUNK = 8;

  // Per-stage control record: valid bit and the carry handed to the next slice.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  // Number of pipeline stages, one CHUNK-bit slice each.
  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned chunk);
    return width / chunk;
  endfunction

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/pipelined_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
module pipelined_adder_chunk_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_carry_in
);

  logic [CHUNK:0] carry;
  logic [1:0]     fa;

  // Ripple the carry through the slice one cell at a time.
  always_comb begin
    carry    = '0;
    sum      = '0;
    fa       = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      fa         = full_add(a[i], b[i], carry[i]);
      sum[i]     = fa[0];
      carry[i+1] = fa[1];
    end
  end

  assign cout         = carry[CHUNK];
  assign msb_carry_in = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice resolved per stage.
// Optional subtract mode is enabled by defining ADDER_SUB_EN.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N = num_stages(WIDTH, CHUNK);

  logic             pipe_en_c;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Whole pipeline advances unless a result is stuck at the output.
  always_comb begin
    pipe_en_c = !out_valid || out_ready;
  end

  assign in_ready = pipe_en_c;

  // Operand conditioning: subtract is a + ~b + 1, ignoring cin.
  always_comb begin
    b_eff   = b;
    cin_eff = cin;
`ifdef ADDER_SUB_EN
    if (sub) begin
      b_eff   = ~b;
      cin_eff = 1'b1;
    end
`endif
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    // Operands still to be consumed shrink, the finished sum grows.
    localparam int unsigned RW = WIDTH - k * CHUNK;
    localparam int unsigned SW = (k + 1) * CHUNK;

    logic [RW-1:0]    op_a;
    logic [RW-1:0]    op_b;
    logic             carry_in;
    logic             valid_in;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;
    stage_ctrl_t      ctrl_d;
    stage_ctrl_t      ctrl_q;
    logic [SW-1:0]    sum_d;
    logic [SW-1:0]    sum_q;

    if (k == 0) begin : g_src
      assign op_a     = a;
      assign op_b     = b_eff;
      assign carry_in = cin_eff;
      assign valid_in = in_valid;
      // First slice starts the partial sum.
      always_comb begin
        sum_d = ch_sum;
      end
    end else begin : g_src
      assign op_a     = g_stage[k-1].g_mid.fwd_a_q;
      assign op_b     = g_stage[k-1].g_mid.fwd_b_q;
      assign carry_in = g_stage[k-1].ctrl_q.carry;
      assign valid_in = g_stage[k-1].ctrl_q.valid;
      // Append this slice above the lower chunks already resolved.
      always_comb begin
        sum_d = {ch_sum, g_stage[k-1].sum_q};
      end
    end

    // Stage control: valid travels with the data, carry feeds the next slice.
    always_comb begin
      ctrl_d       = '0;
      ctrl_d.valid = valid_in;
      ctrl_d.carry = ch_cout;
    end

    // Stage result registers, frozen while the output is stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        ctrl_q <= '0;
        sum_q  <= '0;
      end else if (pipe_en_c) begin
        ctrl_q <= ctrl_d;
        sum_q  <= sum_d;
      end
    end

    if (k < N - 1) begin : g_mid
      localparam int unsigned FW = RW - CHUNK;

      logic [FW-1:0] fwd_a_d;
      logic [FW-1:0] fwd_a_q;
      logic [FW-1:0] fwd_b_d;
      logic [FW-1:0] fwd_b_q;
      logic          msb_ci_unused;

      pipelined_adder_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a            (op_a[CHUNK-1:0]),
        .b            (op_b[CHUNK-1:0]),
        .cin          (carry_in),
        .sum          (ch_sum),
        .cout         (ch_cout),
        .msb_carry_in (msb_ci_unused)
      );

      // Upper operand chunks ride along to the later stages.
      always_comb begin
        fwd_a_d = op_a[RW-1:CHUNK];
        fwd_b_d = op_b[RW-1:CHUNK];
      end

      // Skewed operand registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          fwd_a_q <= '0;
          fwd_b_q <= '0;
        end else if (pipe_en_c) begin
          fwd_a_q <= fwd_a_d;
          fwd_b_q <= fwd_b_d;
        end
      end
    end else begin : g_last
      logic msb_ci;
      logic ovf_d;
      logic ovf_q;

      pipelined_adder_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a            (op_a[CHUNK-1:0]),
        .b            (op_b[CHUNK-1:0]),
        .cin          (carry_in),
        .sum          (ch_sum),
        .cout         (ch_cout),
        .msb_carry_in (msb_ci)
      );

      // Signed overflow from the MSB slice: carry into MSB xor carry out.
      always_comb begin
        ovf_d = ch_cout ^ msb_ci;
      end

      // Overflow flag register alongside the final sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (pipe_en_c) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign sum       = g_stage[N-1].sum_q;
  assign cout      = g_stage[N-1].ctrl_q.carry;
  assign out_valid = g_stage[N-1].ctrl_q.valid;
  assign ovf       = g_stage[N-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (default build; sub vectors under ADDER_SUB_EN).
module tb_pipelined_adder;

  localparam int unsigned W = 32;
  localparam int unsigned C = 8;
  localparam int unsigned N = W / C;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_vec = 0;
  int n_bad = 0;
  int n_out = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  res_t exp_q[$];
  vec_t vt[$];

  pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                 input logic cin_i, input logic sub_i);
    logic [W:0]   t;
    logic [W-1:0] bb;
    logic         cc;
    res_t         r;
    bb   = sub_i ? ~b_i : b_i;
    cc   = sub_i ? 1'b1 : cin_i;
    t    = {1'b0, a_i} + {1'b0, bb} + (W+1)'(cc);
    r.s  = t[W-1:0];
    r.co = t[W];
    r.ov = (a_i[W-1] == bb[W-1]) && (t[W-1] != a_i[W-1]);
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted operands, compare consumed results in order.
  always @(negedge clk) begin
    res_t r;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL scoreboard: unexpected result sum=%h cout=%b ovf=%b", sum, cout, ovf);
        end else begin
          r = exp_q.pop_front();
          check("scoreboard", 64'({sum, cout, ovf}), 64'({r.s, r.co, r.ov}));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    sub      = v.sub;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(N));
    check($sformatf("vec%0d_sum", idx), 64'(sum), 64'(v.s));
    check($sformatf("vec%0d_cout", idx), 64'(cout), 64'(v.co));
    check($sformatf("vec%0d_ovf", idx), 64'(ovf), 64'(v.ov));
    step();
  endtask

  initial begin
    int   n0;
    int   nv;
    int   first;
    int   last;
    int   idx;
    logic acc;
    logic [W+2:0] held;

    vt.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0});
    vt.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vt.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vt.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    vt.push_back('{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0});
    vt.push_back('{32'h0000_00FF, 32'h0000_FF01, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0});
    vt.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
    vt.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0});
`ifdef ADDER_SUB_EN
    vt.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vt.push_back('{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0});
    vt.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0});
    vt.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed vectors, one at a time
    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // Streaming: 16 back-to-back random pairs
    n0 = n_out;
    nv = 0;
    first = -1;
    last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 16 + int'(N) + 4; c++) begin
      if (c < 16) begin
        a        = $urandom();
        b        = $urandom();
        cin      = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check("stream_valid_cycles", 64'(nv), 64'(16));
    check("stream_contiguous", 64'(last - first + 1), 64'(16));
    check("stream_results", 64'(n_out - n0), 64'(16));

    // Backpressure: out_ready low for 5 cycles mid-stream
    n0 = n_out;
    idx = 0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 6 && c < 11);
      if (idx < 10) begin
        a        = 32'h1357_9BDF * W'(idx + 1);
        b        = 32'hFEDC_BA98 ^ W'(idx);
        cin      = 1'(idx);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 6 && c < 11) begin
        check($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'(0));
        if (c == 6) held = {sum, cout, ovf, out_valid};
        else check($sformatf("bp_hold_c%0d", c), 64'({sum, cout, ovf, out_valid}), 64'(held));
      end
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    out_ready = 1'b1;
    check("bp_held_valid", 64'(held[0]), 64'(1));
    check("bp_results", 64'(n_out - n0), 64'(10));
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // Reset with three transactions in flight
    n0 = n_out;
    for (int c = 0; c < 3; c++) begin
      a        = 32'hAAAA_0000 + W'(c);
      b        = 32'h0000_5555;
      cin      = 1'b0;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid) nv++;
    end
    check("midrst_no_results", 64'(nv), 64'(0));
    check("midrst_no_consumed", 64'(n_out - n0), 64'(0));

    // Pipeline still works after the flush
    run_vec(vt[0], 100);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
